// File: rtl/scan_bist_ctrl.sv
// Logic-BIST scan controller: LFSR-driven pattern load, single capture cycle,
// MISR compaction of the scan-out stream and capture POs, golden compare.
module scan_bist_ctrl #(
  parameter int          CHAIN_LEN = 14,
  parameter int          NUM_PI    = 3,
  parameter int          NUM_PO    = 6,
  parameter int          PAT_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic [PAT_W-1:0]  num_patterns,
  input  logic [15:0]       golden_sig,
  input  logic              scan_out,
  input  logic [NUM_PO-1:0] po,
  output logic              scan_en,
  output logic              scan_in,
  output logic [NUM_PI-1:0] pi,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       signature
);

  localparam int SC_W = $clog2(CHAIN_LEN);
  localparam logic [SC_W-1:0] SHIFT_LAST = SC_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [15:0] misr_next(input logic [15:0] m, input logic [15:0] d);
    return {m[14:0], 1'b0} ^ (m[15] ? 16'h6801 : 16'h0000) ^ d;
  endfunction

  state_t              state_r;
  logic [15:0]         lfsr_r;
  logic [15:0]         misr_r;
  logic [15:0]         golden_r;
  logic [PAT_W-1:0]    n_r;
  logic [PAT_W-1:0]    pat_cnt_r;
  logic [SC_W-1:0]     shift_cnt_r;
  logic                first_load_r;
  logic                scan_en_r;
  logic                scan_in_r;
  logic [NUM_PI-1:0]   pi_r;
  logic                busy_r;
  logic                done_r;
  logic                pass_r;
  logic [15:0]         signature_r;

  logic [15:0]         misr_in_s;
  logic                misr_en_s;
  logic [15:0]         misr_nxt_s;
  logic [PAT_W-1:0]    pat_cnt_inc_s;

  assign pat_cnt_inc_s = pat_cnt_r + PAT_W'(1);

  // MISR input selection; the first load's shift-out is unknown chain content and is skipped
  always_comb begin
    misr_in_s = 16'h0000;
    misr_en_s = 1'b0;
    case (state_r)
      ST_SHIFT: begin
        misr_in_s = {15'h0000, scan_out};
        misr_en_s = ~first_load_r;
      end
      ST_CAPTURE: begin
        misr_in_s = {{(16-NUM_PO){1'b0}}, po};
        misr_en_s = 1'b1;
      end
      ST_UNLOAD: begin
        misr_in_s = {15'h0000, scan_out};
        misr_en_s = 1'b1;
      end
      default: begin
        misr_in_s = 16'h0000;
        misr_en_s = 1'b0;
      end
    endcase
    if (misr_en_s) begin
      misr_nxt_s = misr_next(misr_r, misr_in_s);
    end else begin
      misr_nxt_s = misr_r;
    end
  end

  // Control FSM; scan_in is registered one step ahead so the LFSR runs one state in front of it
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      lfsr_r       <= LFSR_SEED;
      misr_r       <= 16'h0000;
      golden_r     <= 16'h0000;
      n_r          <= '0;
      pat_cnt_r    <= '0;
      shift_cnt_r  <= '0;
      first_load_r <= 1'b0;
      scan_en_r    <= 1'b0;
      scan_in_r    <= 1'b0;
      pi_r         <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      signature_r  <= 16'h0000;
    end else begin
      misr_r <= misr_nxt_s;
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            n_r         <= num_patterns;
            golden_r    <= golden_sig;
            pat_cnt_r   <= '0;
            shift_cnt_r <= '0;
            misr_r      <= 16'h0000;
            if (num_patterns != '0) begin
              state_r      <= ST_SHIFT;
              scan_in_r    <= LFSR_SEED[0];
              lfsr_r       <= lfsr_next(LFSR_SEED);
              first_load_r <= 1'b1;
              scan_en_r    <= 1'b1;
              busy_r       <= 1'b1;
              pass_r       <= 1'b0;
              signature_r  <= 16'h0000;
            end else begin
              state_r     <= ST_DONE;
              lfsr_r      <= LFSR_SEED;
              done_r      <= 1'b1;
              signature_r <= 16'h0000;
              pass_r      <= (golden_sig == 16'h0000);
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (shift_cnt_r == SHIFT_LAST) begin
            state_r     <= ST_CAPTURE;
            shift_cnt_r <= '0;
            scan_en_r   <= 1'b0;
            scan_in_r   <= 1'b0;
            pi_r        <= lfsr_r[NUM_PI:1];
          end else begin
            shift_cnt_r <= shift_cnt_r + SC_W'(1);
            scan_in_r   <= lfsr_r[0];
            lfsr_r      <= lfsr_next(lfsr_r);
          end
        end
        ST_CAPTURE: begin
          pat_cnt_r    <= pat_cnt_inc_s;
          first_load_r <= 1'b0;
          scan_en_r    <= 1'b1;
          if (pat_cnt_inc_s == n_r) begin
            state_r   <= ST_UNLOAD;
            scan_in_r <= 1'b0;
          end else begin
            state_r   <= ST_SHIFT;
            scan_in_r <= lfsr_r[0];
            lfsr_r    <= lfsr_next(lfsr_r);
          end
        end
        ST_UNLOAD: begin
          if (shift_cnt_r == SHIFT_LAST) begin
            state_r     <= ST_DONE;
            shift_cnt_r <= '0;
            scan_en_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            signature_r <= misr_nxt_s;
            pass_r      <= (misr_nxt_s == golden_r);
          end else begin
            shift_cnt_r <= shift_cnt_r + SC_W'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          scan_en_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign scan_en   = scan_en_r;
  assign scan_in   = scan_in_r;
  assign pi        = pi_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign signature = signature_r;

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// Bench for scan_bist_ctrl: a loopback chain model feeds scan_out, and a
// pattern-level reference computes the scan_in stream, pi values and signature.
module tb_scan_bist_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        CK;
  logic        RST;
  logic        start;
  logic [7:0]  num_patterns;
  logic [15:0] golden_sig;
  logic        scan_out;
  logic [5:0]  po;
  logic        scan_en;
  logic        scan_in;
  logic [2:0]  pi;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;

  int checks = 0;
  int errors = 0;

  logic [13:0] chain;
  logic        sin_exp [0:255];
  logic [2:0]  pi_exp  [0:15];
  logic [15:0] clean_sig;
  logic [15:0] run_sig;
  logic [3:0]  first_bits;

  scan_bist_ctrl dut (
    .CK(CK), .RST(RST), .start(start), .num_patterns(num_patterns),
    .golden_sig(golden_sig), .scan_out(scan_out), .po(po),
    .scan_en(scan_en), .scan_in(scan_in), .pi(pi), .busy(busy),
    .done(done), .pass(pass), .signature(signature)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // core scan chain in loopback: shifts when scan_en, holds during capture
  always @(posedge CK) begin
    if (scan_en) chain <= {chain[12:0], scan_in};
  end
  assign scan_out = chain[13];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [15:0] d);
    return {m[14:0], 1'b0} ^ (m[15] ? 16'h6801 : 16'h0000) ^ d;
  endfunction

  // pattern-level reference: each pattern's bits come back out during the next load
  task automatic model(input int n, input logic [5:0] pov, output logic [15:0] sig);
    logic [15:0] l;
    logic [15:0] m;
    logic [13:0] prev;
    logic [13:0] cur;
    l = SEED;
    m = 16'h0000;
    prev = 14'h0;
    cur = 14'h0;
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < 14; k++) begin
        sin_exp[p*14+k] = l[0];
        cur[k] = l[0];
        if (p > 0) m = misr_step(m, {15'h0000, prev[k]});
        l = lfsr_step(l);
      end
      pi_exp[p] = l[3:1];
      m = misr_step(m, {10'h000, pov});
      prev = cur;
    end
    for (int k = 0; k < 14; k++) m = misr_step(m, {15'h0000, prev[k]});
    sig = m;
  endtask

  task automatic do_run(input int n, input logic [5:0] pov, input logic [15:0] gold,
                        input bit mid_start, input logic [15:0] exp_sig,
                        output logic [15:0] sig_o);
    int b;
    int ph;
    int p;
    po = pov;
    num_patterns = 8'(n);
    golden_sig = gold;
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    b = 0;
    while (busy === 1'b1 && b < 2000) begin
      if (b < n*15) begin
        ph = b % 15;
        p = b / 15;
        if (ph < 14) begin
          chk("scan_en_shift", scan_en, 1'b1);
          chk("scan_in_shift", scan_in, sin_exp[b - p]);
          if (b < 4) first_bits[b] = scan_in;
        end else begin
          chk("scan_en_capture", scan_en, 1'b0);
          chk("pi_capture", pi, pi_exp[p]);
        end
      end else begin
        chk("scan_en_unload", scan_en, 1'b1);
        chk("scan_in_unload", scan_in, 1'b0);
      end
      chk("done_during_run", done, 1'b0);
      if (mid_start && b == 20) begin
        start = 1'b1;
        num_patterns = 8'(n + 3);
        golden_sig = ~gold;
      end
      if (mid_start && b == 22) start = 1'b0;
      @(posedge CK); #1;
      b++;
    end
    chk("busy_cycles", b, n*15 + 14);
    chk("done_pulse", done, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    chk("signature", signature, exp_sig);
    chk("pass", pass, (gold == exp_sig) ? 1'b1 : 1'b0);
    sig_o = signature;
    @(posedge CK); #1;
    chk("done_one_cycle", done, 1'b0);
    chk("signature_held", signature, exp_sig);
  endtask

  initial begin
    logic [15:0] ms;
    int n;
    logic [5:0] pv;
    logic [15:0] g;
    RST = 1'b1;
    start = 1'b0;
    num_patterns = 8'h00;
    golden_sig = 16'h0000;
    po = 6'h00;
    first_bits = 4'h0;
    repeat (3) @(posedge CK);
    #1;
    chk("rst_outputs", {scan_en, scan_in, pi, busy, done, pass, signature}, 24'h0);
    RST = 1'b0;
    @(posedge CK); #1;
    chk("idle_outputs", {scan_en, scan_in, pi, busy, done, pass, signature}, 24'h0);

    // N=1 timing and first LFSR bits
    model(1, 6'h15, ms);
    do_run(1, 6'h15, ms, 1'b0, ms, run_sig);
    chk("first_scan_in_bits", first_bits, 4'b0001);

    // loopback N=3, po=2A, golden from model and then corrupted
    model(3, 6'h2A, ms);
    do_run(3, 6'h2A, ms, 1'b0, ms, clean_sig);
    do_run(3, 6'h2A, ms ^ 16'h0001, 1'b0, ms, run_sig);

    // N=0 straight to DONE
    po = 6'h00;
    num_patterns = 8'h00;
    golden_sig = 16'h0000;
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    chk("n0_done", done, 1'b1);
    chk("n0_pass", pass, 1'b1);
    chk("n0_signature", signature, 16'h0000);
    chk("n0_scan_en", scan_en, 1'b0);
    chk("n0_busy", busy, 1'b0);
    @(posedge CK); #1;
    chk("n0_done_clear", done, 1'b0);
    chk("n0_scan_en_after", scan_en, 1'b0);
    golden_sig = 16'h0100;
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    chk("n0_fail_done", done, 1'b1);
    chk("n0_fail_pass", pass, 1'b0);
    @(posedge CK); #1;

    // start pulsed mid-run is ignored
    model(2, 6'h33, ms);
    do_run(2, 6'h33, ms, 1'b1, ms, run_sig);

    // reset during SHIFT cycle 5 aborts the run
    po = 6'h2A;
    num_patterns = 8'd3;
    golden_sig = 16'h0000;
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    repeat (5) @(posedge CK);
    #1;
    chk("pre_abort_busy", busy, 1'b1);
    RST = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_scan_en", scan_en, 1'b0);
    repeat (3) begin
      @(posedge CK); #1;
      chk("abort_no_done", done, 1'b0);
    end
    RST = 1'b0;
    @(posedge CK); #1;
    chk("abort_outputs", {scan_en, scan_in, pi, busy, done, pass, signature}, 24'h0);
    model(3, 6'h2A, ms);
    do_run(3, 6'h2A, ms, 1'b0, ms, run_sig);
    chk("rerun_matches_clean", run_sig, clean_sig);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 5));
      pv = 6'($urandom);
      model(n, pv, ms);
      if ($urandom_range(0, 1) == 0) g = ms;
      else g = ms ^ (16'h0001 << $urandom_range(0, 15));
      do_run(n, pv, g, ($urandom_range(0, 2) == 0), ms, run_sig);
      repeat ($urandom_range(0, 3)) @(posedge CK);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_bist_ctrl.md
Name: scan_bist_ctrl

Overview:
- Logic-BIST scan controller for a single 14-flop full-scan chain with 3 primary inputs and 6 primary outputs.
- Runs N pseudo-random patterns through the chain: an LFSR loads each pattern, a capture cycle applies it, and a MISR compacts the scan-out stream and the capture-cycle POs.
- Reports the signature and a pass/fail result against a golden value.
- Sits between the test access logic and the scan-inserted core.

Parameters:
CHAIN_LEN, 14, scan chain length in flops
NUM_PI, 3, core primary inputs driven during capture
NUM_PO, 6, core primary outputs compacted during capture
PAT_W, 8, width of pattern count
LFSR_SEED, 16'hACE1, LFSR reset and start value (must be nonzero)

Ports:
CK  in  1  clock; all state updates on rising edge
RST  in  1  asynchronous reset, active-high
start  in  1  begin a run; sampled only in IDLE
num_patterns  in  PAT_W  pattern count N; sampled with start
golden_sig  in  16  expected signature; sampled with start
scan_out  in  1  serial output of the chain's last flop
po  in  NUM_PO  core primary outputs
scan_en  out  1  chain shift enable (1 = shift, 0 = functional capture)
scan_in  out  1  serial data into the chain's first flop
pi  out  NUM_PI  core primary inputs
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
pass  out  1  signature == golden; valid from done, held until next start
signature  out  16  final MISR value; held until next start

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, scan_en=0, scan_in=0, pi=0, busy=0, done=0, pass=0, signature=0, LFSR=LFSR_SEED, MISR=0, counters=0.
- Reset asserted mid-run aborts immediately: no done pulse, and all reset values apply.
- States: IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE, start=1, N>0: LFSR<=LFSR_SEED, MISR<=0, first_load<=1, latch N and golden_sig, go to SHIFT.
- IDLE, start=1, N=0: go straight to DONE; signature=0; pass=(golden_sig==0).
- start is ignored outside IDLE.
- SHIFT (CHAIN_LEN cycles, scan_en=1):
  - scan_in = LFSR[0], then LFSR advances: fb = L[0]^L[2]^L[3]^L[5]; L <= {fb, L[15:1]}.
  - MISR compacts scan_out unless first_load=1.
  - After the last shift cycle, go to CAPTURE.
- CAPTURE (1 cycle, scan_en=0):
  - pi = LFSR[NUM_PI:1], registered on entry to CAPTURE and held until the next CAPTURE or reset.
  - MISR compacts po.
  - Pattern count increments and first_load clears.
  - If count == N go to UNLOAD, else go to SHIFT.
- UNLOAD (CHAIN_LEN cycles, scan_en=1):
  - scan_in=0, LFSR frozen.
  - MISR compacts scan_out.
  - After the last cycle, go to DONE.
- DONE (1 cycle): done=1, signature <= MISR, pass <= (MISR==golden), busy drops, return to IDLE.
- busy=1 in SHIFT, CAPTURE and UNLOAD. Run length = N*(CHAIN_LEN+1)+CHAIN_LEN busy cycles.
- MISR update: M <= {M[14:0],1'b0} ^ (M[15] ? 16'h6801 : 0) ^ d.
  - In SHIFT/UNLOAD: d = {15'b0, scan_out}.
  - In CAPTURE: d = {(16-NUM_PO)'b0, po}.
  - Otherwise M holds.
- The shift-out of the previous pattern overlaps the shift-in of the next pattern. The first load's shift-out is never compacted, because the chain contents are unknown at that point.

Test Plan:
- Reset checks:
  - After RST pulse: all outputs 0; LFSR=0xACE1.
  - Assert RST during SHIFT cycle 5: busy=0 and scan_en=0 immediately; no done pulse; a subsequent run matches a clean run.
- N=1 timing: start with N=1 -> busy high 29 cycles; scan_en 14 high, 1 low, 14 high; done pulse the cycle after busy falls.
- LFSR sequence: first four scan_in values are 1,0,0,0 (LFSR 0xACE1, 0x5670, 0xAB38, 0x559C); first pi = LFSR[3:1] of the state at CAPTURE entry, checked against the model.
- Loopback signature:
  - Chain modelled as a 14-deep shift register, po=6'h2A, N=3, golden = model MISR -> pass=1, signature = model value.
  - Rerun with golden XOR 1 -> pass=0.
- Zero patterns and busy start:
  - N=0, golden=0 -> done on the 2nd cycle after start, pass=1, scan_en never asserted.
  - start pulsed mid-run -> ignored; run length unchanged.
